// File: rtl/button_pio_pkg.sv
// Shared definitions for the push-button PIO slave: bus data width and the
// word addresses of the software-visible registers.
package button_pio_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

endpackage : button_pio_pkg

// File: rtl/button_debounce_bit.sv
// One button channel: two-flop synchroniser, stability counter and debounced
// level, plus a one-cycle press pulse.
// Ports:
//   clk, reset_n  - clock and synchronous active-low reset
//   raw           - asynchronous button pin, 0 = pressed
//   level         - debounced level (resets to 1 = released)
//   press_pulse   - high for the single cycle whose closing edge drops level 1->0
module button_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic press_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic [CNT_W-1:0] cnt_r;
    logic             cnt_last_s;

    assign cnt_last_s = (cnt_r == CNT_LAST);

    // Synchroniser, stability counter and debounced level.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            level_r <= 1'b1;
            cnt_r   <= '0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            // Any return to the current level restarts the stability count.
            if (sync2_r == level_r) begin
                cnt_r <= '0;
            end else if (cnt_last_s) begin
                level_r <= sync2_r;
                cnt_r   <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    // The pulse is produced from the same condition that drops the level so the
    // capture register and the level change on the same edge.
    always_comb begin
        press_pulse = level_r & ~sync2_r & cnt_last_s;
    end

    assign level = level_r;

endmodule : button_debounce_bit

// File: rtl/button_pio_edge_slave.sv
// Avalon-MM slave for the board push-buttons: debounced DATA register,
// interrupt mask, sticky press edge-capture and a level interrupt.
// Ports:
//   clk, reset_n              - clock and synchronous active-low reset
//   in_port[WIDTH]            - raw button pins, 0 = pressed
//   address, chipselect,
//   read, write, writedata    - Avalon-MM slave request (no waitrequest)
//   readdata                  - registered read data, latency 1
//   irq                       - registered level interrupt
module button_pio_edge_slave
    import button_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WIDTH-1:0]  in_port,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              irq
);

    logic [WIDTH-1:0]  level_s;
    logic [WIDTH-1:0]  press_s;
    logic [WIDTH-1:0]  mask_r;
    logic [WIDTH-1:0]  edge_r;
    logic [WIDTH-1:0]  mask_next_s;
    logic [WIDTH-1:0]  edge_next_s;
    logic [DATA_W-1:0] rd_mux_s;
    logic [DATA_W-1:0] readdata_r;
    logic              irq_r;
    logic              rd_s;
    logic              wr_s;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        button_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk         (clk),
            .reset_n     (reset_n),
            .raw         (in_port[i]),
            .level       (level_s[i]),
            .press_pulse (press_s[i])
        );
    end

    assign rd_s = chipselect & read;
    assign wr_s = chipselect & write;

    // Next mask/capture values; a press in the same cycle as a clear keeps the bit set.
    always_comb begin
        mask_next_s = mask_r;
        edge_next_s = edge_r | press_s;
        if (wr_s && (address == ADDR_MASK)) begin
            mask_next_s = writedata[WIDTH-1:0];
        end else begin
            mask_next_s = mask_r;
        end
        if (wr_s && (address == ADDR_EDGE)) begin
            edge_next_s = (edge_r & ~writedata[WIDTH-1:0]) | press_s;
        end else begin
            edge_next_s = edge_r | press_s;
        end
    end

    // Read mux over the pre-edge register values, zero-extended to the bus.
    always_comb begin
        rd_mux_s = '0;
        case (address)
            ADDR_DATA: rd_mux_s[WIDTH-1:0] = ~level_s;
            ADDR_MASK: rd_mux_s[WIDTH-1:0] = mask_r;
            ADDR_EDGE: rd_mux_s[WIDTH-1:0] = edge_r;
            default:   rd_mux_s = '0;
        endcase
    end

    // Register file, registered read data and interrupt.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mask_r     <= '0;
            edge_r     <= '0;
            readdata_r <= '0;
            irq_r      <= 1'b0;
        end else begin
            mask_r <= mask_next_s;
            edge_r <= edge_next_s;
            irq_r  <= |(edge_next_s & mask_next_s);
            if (rd_s) begin
                readdata_r <= rd_mux_s;
            end
        end
    end

    assign readdata = readdata_r;
    assign irq      = irq_r;

endmodule : button_pio_edge_slave

// File: tb/tb_button_pio_edge_slave.sv
module tb_button_pio_edge_slave;

    localparam int W   = 4;
    localparam int DEB = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  in_port;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    button_pio_edge_slave #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB), .CNT_W(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_port    (in_port),
        .address    (address),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    typedef struct {
        logic [1:0]  addr;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus(input logic [1:0] a, input logic r, input logic w, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        read       = r;
        write      = w;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = 32'h0;
    endtask

    task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
        bus(a, 1'b1, 1'b0, 32'h0);
        check(name, readdata, exp);
    endtask

    task automatic run_table(input string name, input vec_t v[]);
        for (int i = 0; i < v.size(); i++) begin
            bus(v[i].addr, v[i].rd, v[i].wr, v[i].wdata);
            if (v[i].rd) check($sformatf("%s[%0d] readdata", name, i), readdata, v[i].exp_rd);
            check($sformatf("%s[%0d] irq", name, i), {31'h0, irq}, {31'h0, v[i].exp_irq});
        end
    endtask

    vec_t reset_tab[];
    vec_t reg_tab[];

    initial begin
        reset_tab = '{
            '{2'd0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0},
            '{2'd2, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0},
            '{2'd3, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0}
        };
        // Entered with EDGE=0x3, MASK=0, bit0 held pressed.
        reg_tab = '{
            '{2'd3, 1'b0, 1'b1, 32'h1,         32'h0, 1'b0},  // clear bit0
            '{2'd2, 1'b0, 1'b1, 32'hFFFF_FFF2, 32'h0, 1'b1},  // mask overlaps bit1
            '{2'd2, 1'b1, 1'b0, 32'h0,         32'h2, 1'b1},  // upper bits read 0
            '{2'd2, 1'b1, 1'b1, 32'h0,         32'h2, 1'b0},  // read sees pre-write
            '{2'd2, 1'b0, 1'b1, 32'h2,         32'h0, 1'b1},
            '{2'd3, 1'b0, 1'b1, 32'h2,         32'h0, 1'b0},  // clear drops irq
            '{2'd3, 1'b1, 1'b0, 32'h0,         32'h0, 1'b0},
            '{2'd0, 1'b0, 1'b1, 32'hF,         32'h0, 1'b0},  // DATA write ignored
            '{2'd0, 1'b1, 1'b0, 32'h0,         32'h1, 1'b0},
            '{2'd1, 1'b1, 1'b1, 32'hF,         32'h0, 1'b0}   // reserved
        };

        reset_n    = 1'b0;
        in_port    = 4'hF;
        address    = 2'd0;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = 32'h0;
        repeat (3) tick();
        reset_n = 1'b1;
        check("reset readdata", readdata, 32'h0);
        check("reset irq", {31'h0, irq}, 32'h0);
        run_table("reset_reads", reset_tab);

        // Bit0 press: level falls on the 10th edge after the change.
        in_port = 4'b1110;
        repeat (9) tick();
        rd_check("data before debounce", 2'd0, 32'h0);
        rd_check("data after debounce", 2'd0, 32'h1);
        rd_check("edge bit0 captured", 2'd3, 32'h1);

        // Short glitch on bit1 is rejected.
        in_port = 4'b1100;
        repeat (5) tick();
        in_port = 4'b1110;
        repeat (15) tick();
        rd_check("glitch data", 2'd0, 32'h1);
        rd_check("glitch edge", 2'd3, 32'h1);

        // Long press on bit1 is captured; its release is not.
        in_port = 4'b1100;
        repeat (12) tick();
        in_port = 4'b1110;
        repeat (15) tick();
        rd_check("long press edge", 2'd3, 32'h3);
        rd_check("after release data", 2'd0, 32'h1);
        check("irq masked off", {31'h0, irq}, 32'h0);

        run_table("regs", reg_tab);

        // Clear of bit2 lands on the edge that sets it: the set wins.
        in_port = 4'b1010;
        repeat (9) tick();
        bus(2'd3, 1'b0, 1'b1, 32'h4);
        check("set wins irq", {31'h0, irq}, 32'h0);
        rd_check("set wins edge", 2'd3, 32'h4);
        bus(2'd2, 1'b0, 1'b1, 32'h4);
        check("mask bit2 irq", {31'h0, irq}, 32'h1);

        // Mid-debounce reset with every button held.
        in_port = 4'b0000;
        repeat (5) tick();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        check("post-reset readdata", readdata, 32'h0);
        check("post-reset irq", {31'h0, irq}, 32'h0);
        repeat (8) tick();
        rd_check("post-reset edge e9", 2'd3, 32'h0);
        rd_check("post-reset edge e10", 2'd3, 32'h0);
        rd_check("post-reset edge e11", 2'd3, 32'hF);
        rd_check("post-reset data", 2'd0, 32'hF);
        check("post-reset irq mask0", {31'h0, irq}, 32'h0);

        // Releases never set capture.
        bus(2'd3, 1'b0, 1'b1, 32'hF);
        in_port = 4'hF;
        repeat (15) tick();
        rd_check("release no edge", 2'd3, 32'h0);
        rd_check("release data", 2'd0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_button_pio_edge_slave
